pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 142 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor states; the encoding is visible on state_o for debug.
    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } pll_sup_state_e;

    // Defaults sized for a 50 MHz reference clock.
    localparam int unsigned DefRstHoldCyc    = 1000;
    localparam int unsigned DefLockTimeoutCyc = 50000;
    localparam int unsigned DefLockStableCyc = 256;
    localparam int unsigned DefMaxRetry      = 7;
    localparam int unsigned DefCntW          = 16;

    // Width of the failed-attempt counter.
    localparam int unsigned RetryW = 4;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    // Two back-to-back flops give the first stage a cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL supervisor: sequences the PLL reset, debounces lock, handles timeout with
// bounded retries, loss-of-lock recovery and software relock, and produces a
// clean active-low system reset in the refclk domain.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC     = DefRstHoldCyc,
    parameter int unsigned LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
    parameter int unsigned LOCK_STABLE_CYC  = DefLockStableCyc,
    parameter int unsigned MAX_RETRY        = DefMaxRetry,
    parameter int unsigned CNT_W            = DefCntW
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked_i,
    input  logic              relock_req_i,
    output logic              pll_rst_o,
    output logic              sys_rst_n_o,
    output logic              lock_ok_o,
    output logic              fault_o,
    output logic [RetryW-1:0] retry_cnt_o,
    output logic [2:0]        state_o
);

    localparam logic [CNT_W-1:0]  HoldLast    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  StableTgt   = CNT_W'(LOCK_STABLE_CYC);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);

    pll_sup_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;        // hold period in PLL_RST, timeout otherwise
    logic [CNT_W-1:0]  stable_q, stable_d;  // consecutive lock_s cycles
    logic [RetryW-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]  cnt_inc, stable_inc;
    logic [RetryW-1:0] retry_inc;
    logic              lock_s;
    logic              expired;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    // Saturating increments and timeout detection.
    always_comb begin
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        stable_inc = (stable_q == '1) ? stable_q : stable_q + CNT_W'(1);
        retry_inc  = (retry_q == '1) ? retry_q : retry_q + RetryW'(1);
        expired    = (cnt_q >= TimeoutLast);
    end

    // Next-state logic; relock request overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        retry_d  = retry_q;
        if (relock_req_i) begin
            state_d  = StPllRst;
            cnt_d    = '0;
            stable_d = '0;
            retry_d  = '0;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    stable_d = '0;
                    if (cnt_q >= HoldLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                // Lock acquisition: the timeout keeps running across lock glitches,
                // so a bouncing lock is still bounded by the timeout. Reaching the
                // stable target beats a coincident expiry.
                StWaitLock, StStable: begin
                    cnt_d    = cnt_inc;
                    stable_d = lock_s ? stable_inc : '0;
                    if (lock_s && (stable_inc >= StableTgt)) begin
                        state_d  = StRun;
                        cnt_d    = '0;
                        stable_d = '0;
                        retry_d  = '0;
                    end else if (expired) begin
                        cnt_d    = '0;
                        stable_d = '0;
                        retry_d  = retry_inc;
                        state_d  = (retry_inc >= RetryMax) ? StFault : StPllRst;
                    end else begin
                        state_d = lock_s ? StStable : StWaitLock;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_d = StPllRst;
                        cnt_d   = '0;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d  = StPllRst;
                    cnt_d    = '0;
                    stable_d = '0;
                    retry_d  = '0;
                end
            endcase
        end
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they change on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPllRst;
            cnt_q       <= '0;
            stable_q    <= '0;
            retry_q     <= '0;
            pll_rst_o   <= 1'b1;
            sys_rst_n_o <= 1'b0;
            lock_ok_o   <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            pll_rst_o   <= (state_d == StPllRst) || (state_d == StFault);
            sys_rst_n_o <= (state_d == StRun);
            lock_ok_o   <= (state_d == StRun);
            fault_o     <= (state_d == StFault);
        end
    end

    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random
// lock/relock/reset stimulus, compared every cycle against a behavioural model.
module tb_pll_lock_supervisor;

    localparam int HOLD = 4;
    localparam int TMO  = 20;
    localparam int STB  = 8;
    localparam int MAXR = 3;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst_n, lock_ok, fault;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail = 0;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_HOLD_CYC     (HOLD),
        .LOCK_TIMEOUT_CYC (TMO),
        .LOCK_STABLE_CYC  (STB),
        .MAX_RETRY        (MAXR),
        .CNT_W            (16)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked_i (pll_locked),
        .relock_req_i (relock_req),
        .pll_rst_o    (pll_rst),
        .sys_rst_n_o  (sys_rst_n),
        .lock_ok_o    (lock_ok),
        .fault_o      (fault),
        .retry_cnt_o  (retry_cnt),
        .state_o      (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model. Phases: 0 PLL held in reset, 1 acquiring lock,
    // 2 running, 3 fault. Acquisition is tracked as time since release and the
    // length of the current run of synchronized-lock samples.
    int m_phase, m_hold, m_elapsed, m_streak, m_retry;
    bit m_pipe[$];

    function automatic void model_reset();
        m_phase = 0;
        m_hold = 0;
        m_elapsed = 0;
        m_streak = 0;
        m_retry = 0;
        m_pipe.delete();
        m_pipe.push_back(1'b0);
        m_pipe.push_back(1'b0);
    endfunction

    function automatic void model_step(input bit locked, input bit relock);
        bit ls;
        ls = m_pipe.pop_front();
        m_pipe.push_back(locked);
        if (relock) begin
            m_phase = 0;
            m_hold = 0;
            m_retry = 0;
            return;
        end
        case (m_phase)
            0: begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_phase = 1;
                    m_elapsed = 0;
                    m_streak = 0;
                end
            end
            1: begin
                m_elapsed++;
                m_streak = ls ? m_streak + 1 : 0;
                if (m_streak >= STB) begin
                    m_phase = 2;
                    m_retry = 0;
                end else if (m_elapsed >= TMO) begin
                    m_retry++;
                    m_streak = 0;
                    if (m_retry == MAXR) m_phase = 3;
                    else begin
                        m_phase = 0;
                        m_hold = 0;
                    end
                end
            end
            2: begin
                if (!ls) begin
                    m_phase = 0;
                    m_hold = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int model_state();
        case (m_phase)
            0: return 0;
            1: return (m_streak > 0) ? 2 : 1;
            2: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check_all();
        check_eq("state", 32'(state), 32'(model_state()));
        check_eq("pll_rst", 32'(pll_rst), 32'(m_phase == 0 || m_phase == 3));
        check_eq("sys_rst_n", 32'(sys_rst_n), 32'(m_phase == 2));
        check_eq("lock_ok", 32'(lock_ok), 32'(m_phase == 2));
        check_eq("fault", 32'(fault), 32'(m_phase == 3));
        check_eq("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    endtask

    // One clock: model consumes the inputs present at the edge, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge refclk);
        if (rst_n) model_step(pll_locked, relock_req);
        #1;
        check_all();
    endtask

    // Drop rst_n between edges and expect reset values with no clock edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_pll_rst", 32'(pll_rst), 32'd1);
        check_eq("arst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check_eq("arst_lock_ok", 32'(lock_ok), 32'd0);
        check_eq("arst_fault", 32'(fault), 32'd0);
        check_eq("arst_retry", 32'(retry_cnt), 32'd0);
        check_eq("arst_state", 32'(state), 32'd0);
    endtask

    // Length of the current pll_rst high period, counted from the present sample.
    task automatic measure_pll_rst(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!pll_rst) break;
            n++;
            tick();
        end
    endtask

    task automatic wait_lock_ok(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (lock_ok) begin
                found = 1;
                break;
            end
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, found, p, mode, len;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_all();
        repeat (3) tick();
        rst_n = 1'b1;

        // 1: power-up, lock rises 6 cycles after release.
        measure_pll_rst(n);
        check_eq("s1_hold_len", 32'(n), 32'(HOLD));
        repeat (2) tick();
        pll_locked = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (sys_rst_n) break;
        end
        check_eq("s1_lock_to_sysrst", 32'(n), 32'd10);
        check_eq("s1_lock_ok", 32'(lock_ok), 32'd1);
        check_eq("s1_retry", 32'(retry_cnt), 32'd0);
        repeat (5) tick();

        // 4: single-cycle lock drop in RUN.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (!sys_rst_n) break;
        end
        check_eq("s4_drop_edges", 32'(n), 32'd3);
        check_eq("s4_lock_ok", 32'(lock_ok), 32'd0);
        measure_pll_rst(n);
        check_eq("s4_hold_len", 32'(n), 32'(HOLD));
        wait_lock_ok("s4_resequence");

        // 2: lock stuck low -> three attempts then FAULT; relock clears it.
        pll_locked = 1'b0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (fault) begin
                found = 1;
                break;
            end
        end
        check_eq("s2_fault_seen", 32'(found), 32'd1);
        check_eq("s2_retry", 32'(retry_cnt), 32'(MAXR));
        repeat (10) tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check_eq("s2_fault_cleared", 32'(fault), 32'd0);
        check_eq("s2_retry_cleared", 32'(retry_cnt), 32'd0);
        measure_pll_rst(n);
        check_eq("s2_hold_len", 32'(n), 32'(HOLD));

        // 3: lock bouncing 5 high / 1 low never debounces; timeout at 20 cycles.
        p = 0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            pll_locked = ((p % 6) != 5);
            p++;
            tick();
            n++;
            if (retry_cnt != 4'd0) break;
        end
        check_eq("s3_timeout_len", 32'(n), 32'(TMO));
        check_eq("s3_retry", 32'(retry_cnt), 32'd1);

        // 5: relock on the same edge as the final timeout expiry.
        pll_locked = 1'b0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (m_phase == 1 && m_retry == MAXR - 1 && m_elapsed == TMO - 1) begin
                relock_req = 1'b1;
                tick();
                relock_req = 1'b0;
                found = 1;
                break;
            end
        end
        check_eq("s5_reached", 32'(found), 32'd1);
        check_eq("s5_state", 32'(state), 32'd0);
        check_eq("s5_fault", 32'(fault), 32'd0);
        check_eq("s5_retry", 32'(retry_cnt), 32'd0);

        // 6: asynchronous reset in the middle of STABLE.
        pll_locked = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (m_phase == 1 && m_streak >= 3) begin
                found = 1;
                break;
            end
        end
        check_eq("s6_in_stable", 32'(found), 32'd1);
        async_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        wait_lock_ok("s6_restart");

        // Random lock behaviour, occasional relock and reset.
        for (int seg = 0; seg < 40; seg++) begin
            mode = $urandom_range(0, 3);
            len = $urandom_range(20, 60);
            for (int i = 0; i < len; i++) begin
                case (mode)
                    0: pll_locked = 1'b0;
                    1: pll_locked = 1'b1;
                    2: pll_locked = ($urandom_range(0, 3) != 0);
                    default: pll_locked = ((i % 6) != 5);
                endcase
                relock_req = ($urandom_range(0, 99) == 0);
                tick();
                relock_req = 1'b0;
                if ($urandom_range(0, 299) == 0) begin
                    async_reset();
                    repeat (2) tick();
                    rst_n = 1'b1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
